ml_rowseq: RTL and testbench

- Row sequencer directly upstream of the CRAM row-driver chain (ml_rowdrv2 … ml_rowdrv2_last).
- Clears the row shift register (RSR), injects a single one-hot token at row 0 and steps it row by row.
- At each row it drives smc_write/cram_wl_en for a write or read access, handshaking with the frame-data source on writes.
- Checks the token's arrival at the chain tail, then flushes the token out.

---
 rtl/ml_rowseq.sv | 197 +++++++++++++++++++
 tb/tb_ml_rowseq.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ml_rowseq.sv
// Row sequencer for the CRAM row-driver chain: clears the RSR, walks a one-hot
// token down the rows, strobes each wordline for a read or write, then flushes.
module ml_rowseq #(
    parameter int ROW_W     = 10,
    parameter int SETUP_CYC = 2,
    parameter int ACT_CYC   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_wr,
    input  logic [ROW_W-1:0] num_rows,
    input  logic             abort,
    input  logic             row_ack,
    input  logic             chain_tail,
    output logic             rsr_rst,
    output logic             smc_rsr_in,
    output logic             smc_rsr_inc,
    output logic             smc_write,
    output logic             cram_wl_en,
    output logic             row_req,
    output logic             rd_strobe,
    output logic [ROW_W-1:0] row_idx,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLR,
        S_INJ_HI,
        S_INJ_LO,
        S_DATA,
        S_SETUP,
        S_ACT,
        S_HOLD,
        S_SHIFT_HI,
        S_SHIFT_LO,
        S_FLUSH_HI,
        S_FLUSH_LO,
        S_DONE,
        S_ABORT
    } state_t;

    localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYC - 1);
    localparam logic [3:0] ACT_LAST   = 4'(ACT_CYC - 1);
    localparam logic [ROW_W-1:0] ROW_ONE = ROW_W'(1);

    state_t           r_state;
    state_t           w_state_n;
    logic [3:0]       r_cnt;
    logic [3:0]       w_cnt_n;
    logic [ROW_W-1:0] r_row;
    logic [ROW_W-1:0] w_row_n;
    logic [ROW_W-1:0] r_num;
    logic [ROW_W-1:0] w_num_n;
    logic             r_op;
    logic             w_op_n;
    logic             r_err;
    logic             w_err_n;
    logic             w_last;
    logic             w_abort_ok;

    logic             w_rsr_rst_n;
    logic             w_rsr_in_n;
    logic             w_rsr_inc_n;
    logic             w_write_n;
    logic             w_wl_n;
    logic             w_req_n;
    logic             w_rd_n;
    logic             w_busy_n;
    logic             w_done_n;

    assign row_idx = r_row;
    assign err     = r_err;

    always_comb begin
        w_state_n  = r_state;
        w_cnt_n    = '0;
        w_row_n    = r_row;
        w_num_n    = r_num;
        w_op_n     = r_op;
        w_err_n    = r_err;
        w_last     = (r_row == (r_num - ROW_ONE));
        w_abort_ok = abort &&
                     !(r_state inside {S_IDLE, S_DONE, S_ABORT});

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_err_n = 1'b0;
                    if (num_rows == '0) begin
                        w_state_n = S_DONE;
                    end else begin
                        w_op_n    = op_wr;
                        w_num_n   = num_rows;
                        w_row_n   = '0;
                        w_state_n = S_CLR;
                    end
                end
            end
            S_CLR:    w_state_n = S_INJ_HI;
            S_INJ_HI: w_state_n = S_INJ_LO;
            S_INJ_LO: begin
                w_row_n   = '0;
                w_state_n = r_op ? S_DATA : S_SETUP;
            end
            S_DATA: begin
                if (row_ack) w_state_n = S_SETUP;
            end
            S_SETUP: begin
                if (r_cnt >= SETUP_LAST) w_state_n = S_ACT;
                else w_cnt_n = r_cnt + 4'd1;
            end
            S_ACT: begin
                if (r_cnt >= ACT_LAST) w_state_n = S_HOLD;
                else w_cnt_n = r_cnt + 4'd1;
            end
            S_HOLD: begin
                // Token must be visible at the tail exactly on the last row.
                if (chain_tail != w_last) begin
                    w_err_n   = 1'b1;
                    w_state_n = S_ABORT;
                end else if (w_last) begin
                    w_state_n = S_FLUSH_HI;
                end else begin
                    w_state_n = S_SHIFT_HI;
                end
            end
            S_SHIFT_HI: w_state_n = S_SHIFT_LO;
            S_SHIFT_LO: begin
                if (!w_last) w_row_n = r_row + ROW_ONE;
                w_state_n = r_op ? S_DATA : S_SETUP;
            end
            S_FLUSH_HI: w_state_n = S_FLUSH_LO;
            S_FLUSH_LO: w_state_n = S_DONE;
            S_DONE:     w_state_n = S_IDLE;
            S_ABORT:    w_state_n = S_DONE;
            default:    w_state_n = S_IDLE;
        endcase

        if (w_abort_ok) begin
            w_err_n   = 1'b1;
            w_state_n = S_ABORT;
            w_cnt_n   = '0;
        end

        // Outputs are decoded from the next state so they leave a flop.
        w_rsr_rst_n = (w_state_n inside {S_CLR, S_ABORT});
        w_rsr_in_n  = (w_state_n inside {S_INJ_HI, S_INJ_LO});
        w_rsr_inc_n = (w_state_n inside {S_INJ_HI, S_SHIFT_HI, S_FLUSH_HI});
        w_write_n   = w_op_n && (w_state_n inside {S_SETUP, S_ACT});
        w_wl_n      = (w_state_n == S_ACT);
        w_req_n     = (w_state_n == S_DATA);
        w_rd_n      = !w_op_n && (w_state_n == S_ACT) && (w_cnt_n == ACT_LAST);
        w_busy_n    = !(w_state_n inside {S_IDLE, S_DONE});
        w_done_n    = (w_state_n == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_row       <= '0;
            r_num       <= '0;
            r_op        <= 1'b0;
            r_err       <= 1'b0;
            rsr_rst     <= 1'b0;
            smc_rsr_in  <= 1'b0;
            smc_rsr_inc <= 1'b0;
            smc_write   <= 1'b0;
            cram_wl_en  <= 1'b0;
            row_req     <= 1'b0;
            rd_strobe   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_row       <= w_row_n;
            r_num       <= w_num_n;
            r_op        <= w_op_n;
            r_err       <= w_err_n;
            rsr_rst     <= w_rsr_rst_n;
            smc_rsr_in  <= w_rsr_in_n;
            smc_rsr_inc <= w_rsr_inc_n;
            smc_write   <= w_write_n;
            cram_wl_en  <= w_wl_n;
            row_req     <= w_req_n;
            rd_strobe   <= w_rd_n;
            busy        <= w_busy_n;
            done        <= w_done_n;
        end
    end

endmodule

// File: tb/tb_ml_rowseq.sv
// Directed bench for ml_rowseq with a behavioural row-driver chain on the RSR.
module tb_ml_rowseq;

    localparam int ROW_W = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             op_wr = 1'b0;
    logic [ROW_W-1:0] num_rows = '0;
    logic             abort = 1'b0;
    logic             row_ack = 1'b0;
    logic             chain_tail;
    logic             rsr_rst;
    logic             smc_rsr_in;
    logic             smc_rsr_inc;
    logic             smc_write;
    logic             cram_wl_en;
    logic             row_req;
    logic             rd_strobe;
    logic [ROW_W-1:0] row_idx;
    logic             busy;
    logic             done;
    logic             err;

    logic [15:0] chain = '0;
    logic [3:0]  tail_sel;
    logic        stuck = 1'b0;
    logic        prev_inc = 1'b0;
    logic        tb_op = 1'b0;

    int n_rst = 0;
    int n_inc = 0;
    int n_wl = 0;
    int n_rd = 0;
    int n_done = 0;
    int n_wr = 0;
    int n_busy = 0;
    int n_bad = 0;
    int n_wrbad = 0;

    int tests = 0;
    int fails = 0;

    ml_rowseq #(.ROW_W(ROW_W), .SETUP_CYC(2), .ACT_CYC(4)) dut (
        .clk(clk), .rst(rst), .start(start), .op_wr(op_wr),
        .num_rows(num_rows), .abort(abort), .row_ack(row_ack),
        .chain_tail(chain_tail), .rsr_rst(rsr_rst),
        .smc_rsr_in(smc_rsr_in), .smc_rsr_inc(smc_rsr_inc),
        .smc_write(smc_write), .cram_wl_en(cram_wl_en),
        .row_req(row_req), .rd_strobe(rd_strobe), .row_idx(row_idx),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    assign tail_sel   = num_rows[3:0] - 4'd1;
    assign chain_tail = stuck ? 1'b1 : chain[tail_sel];

    // Chain model plus activity counters, sampled mid-cycle.
    always @(negedge clk) begin
        prev_inc <= smc_rsr_inc;
        if (rsr_rst) chain <= '0;
        else if (smc_rsr_inc && !prev_inc) chain <= {chain[14:0], smc_rsr_in};
        if (smc_rsr_inc && !prev_inc) n_inc <= n_inc + 1;
        if (rsr_rst) n_rst <= n_rst + 1;
        if (cram_wl_en) n_wl <= n_wl + 1;
        if (rd_strobe) n_rd <= n_rd + 1;
        if (done) n_done <= n_done + 1;
        if (smc_write) n_wr <= n_wr + 1;
        if (busy) n_busy <= n_busy + 1;
        if ((cram_wl_en && rsr_rst) || (smc_write && !tb_op)) n_bad <= n_bad + 1;
        if (smc_write && (row_req || smc_rsr_inc || smc_rsr_in ||
                          rsr_rst || done || !busy))
            n_wrbad <= n_wrbad + 1;
    end

    function automatic logic [19:0] outs();
        return {rsr_rst, smc_rsr_in, smc_rsr_inc, smc_write, cram_wl_en,
                row_req, rd_strobe, busy, done, err, row_idx};
    endfunction

    task automatic kick(input logic op, input int n);
        @(negedge clk);
        op_wr    = op;
        tb_op    = op;
        num_rows = ROW_W'(n);
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 500) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        #3;
        tests++;
        if (outs() !== 20'h0) begin
            fails++;
            $display("FAIL reset_outs: got %h want 0", outs());
        end
        @(negedge clk);
        rst = 1'b0;
        abort = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (busy !== 1'b0 || err !== 1'b0) begin
            fails++;
            $display("FAIL idle_abort: busy=%b err=%b want 0 0", busy, err);
        end
        abort = 1'b0;
    endtask

    task automatic test_read();
        int lat;
        int s_rst, s_inc, s_wl, s_rd, s_done, s_bad;
        s_rst = n_rst; s_inc = n_inc; s_wl = n_wl;
        s_rd = n_rd; s_done = n_done; s_bad = n_bad;
        kick(1'b0, 3);
        tests++;
        if (rsr_rst !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL read_clr: rsr_rst=%b busy=%b want 1 1", rsr_rst, busy);
        end
        wait_done(lat);
        tests++;
        if (lat !== 30) begin
            fails++;
            $display("FAIL read_latency: got %0d want 30", lat);
        end
        tests++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL read_end: err=%b busy=%b want 0 0", err, busy);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (n_rst - s_rst !== 1 || n_inc - s_inc !== 4) begin
            fails++;
            $display("FAIL read_rsr: rst=%0d inc=%0d want 1 4",
                     n_rst - s_rst, n_inc - s_inc);
        end
        tests++;
        if (n_wl - s_wl !== 12 || n_rd - s_rd !== 3 || n_done - s_done !== 1) begin
            fails++;
            $display("FAIL read_act: wl=%0d rd=%0d done=%0d want 12 3 1",
                     n_wl - s_wl, n_rd - s_rd, n_done - s_done);
        end
        tests++;
        if (n_bad !== s_bad) begin
            fails++;
            $display("FAIL read_invariant: got %0d want %0d", n_bad, s_bad);
        end
    endtask

    task automatic test_write();
        int lat;
        int w;
        int s_wr, s_wl, s_rd, s_inc, s_done, s_bad, s_wrbad;
        s_wr = n_wr; s_wl = n_wl; s_rd = n_rd; s_inc = n_inc;
        s_done = n_done; s_bad = n_bad; s_wrbad = n_wrbad;
        kick(1'b1, 2);
        for (int r = 0; r < 2; r++) begin
            w = 0;
            while (!row_req && w < 50) begin
                @(negedge clk);
                w++;
            end
            tests++;
            if (row_req !== 1'b1 || row_idx !== ROW_W'(r)) begin
                fails++;
                $display("FAIL write_req%0d: req=%b idx=%0d want 1 %0d",
                         r, row_req, row_idx, r);
            end
            repeat (5) @(negedge clk);
            tests++;
            if (row_req !== 1'b1) begin
                fails++;
                $display("FAIL write_req_hold%0d: got %b want 1", r, row_req);
            end
            row_ack = 1'b1;
            @(negedge clk);
            row_ack = 1'b0;
            tests++;
            if (row_req !== 1'b0 || smc_write !== 1'b1) begin
                fails++;
                $display("FAIL write_req_drop%0d: req=%b wr=%b want 0 1",
                         r, row_req, smc_write);
            end
        end
        wait_done(lat);
        tests++;
        if (done !== 1'b1 || err !== 1'b0) begin
            fails++;
            $display("FAIL write_done: done=%b err=%b want 1 0", done, err);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (n_wr - s_wr !== 12 || n_wl - s_wl !== 8 || n_rd - s_rd !== 0) begin
            fails++;
            $display("FAIL write_counts: wr=%0d wl=%0d rd=%0d want 12 8 0",
                     n_wr - s_wr, n_wl - s_wl, n_rd - s_rd);
        end
        tests++;
        if (n_inc - s_inc !== 3 || n_done - s_done !== 1 ||
            n_bad !== s_bad || n_wrbad !== s_wrbad) begin
            fails++;
            $display("FAIL write_misc: inc=%0d done=%0d bad=%0d wrbad=%0d want 3 1 0 0",
                     n_inc - s_inc, n_done - s_done,
                     n_bad - s_bad, n_wrbad - s_wrbad);
        end
    endtask

    task automatic test_tail_fault();
        int lat;
        int s_rst, s_inc, s_done;
        s_rst = n_rst; s_inc = n_inc; s_done = n_done;
        stuck = 1'b1;
        kick(1'b0, 4);
        wait_done(lat);
        tests++;
        if (lat !== 11) begin
            fails++;
            $display("FAIL tail_latency: got %0d want 11", lat);
        end
        tests++;
        if (err !== 1'b1 || busy !== 1'b0 || row_idx !== '0) begin
            fails++;
            $display("FAIL tail_state: err=%b busy=%b idx=%0d want 1 0 0",
                     err, busy, row_idx);
        end
        repeat (4) @(negedge clk);
        tests++;
        if (n_rst - s_rst !== 2 || n_inc - s_inc !== 1 ||
            n_done - s_done !== 1 || err !== 1'b1) begin
            fails++;
            $display("FAIL tail_after: rst=%0d inc=%0d done=%0d err=%b want 2 1 1 1",
                     n_rst - s_rst, n_inc - s_inc, n_done - s_done, err);
        end
        stuck = 1'b0;
    endtask

    task automatic test_zero_rows();
        int s_rst, s_inc, s_busy, s_done;
        s_rst = n_rst; s_inc = n_inc; s_busy = n_busy; s_done = n_done;
        kick(1'b0, 0);
        tests++;
        if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
            fails++;
            $display("FAIL zero_done: done=%b busy=%b err=%b want 1 0 0",
                     done, busy, err);
        end
        repeat (4) @(negedge clk);
        tests++;
        if (n_rst - s_rst !== 0 || n_inc - s_inc !== 0 ||
            n_busy - s_busy !== 0 || n_done - s_done !== 1) begin
            fails++;
            $display("FAIL zero_quiet: rst=%0d inc=%0d busy=%0d done=%0d want 0 0 0 1",
                     n_rst - s_rst, n_inc - s_inc,
                     n_busy - s_busy, n_done - s_done);
        end
    endtask

    task automatic test_abort();
        int lat;
        int w;
        kick(1'b0, 8);
        w = 0;
        while (!(row_idx == ROW_W'(1) && cram_wl_en) && w < 100) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        tests++;
        if (cram_wl_en !== 1'b1 || row_idx !== ROW_W'(1)) begin
            fails++;
            $display("FAIL abort_act2: wl=%b idx=%0d want 1 1", cram_wl_en, row_idx);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        tests++;
        if (cram_wl_en !== 1'b0 || rsr_rst !== 1'b1 || err !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL abort_enter: wl=%b rsr_rst=%b err=%b busy=%b want 0 1 1 1",
                     cram_wl_en, rsr_rst, err, busy);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b1 || rsr_rst !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_done: done=%b rsr_rst=%b busy=%b want 1 0 0",
                     done, rsr_rst, busy);
        end
        kick(1'b0, 1);
        tests++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL abort_err_clear: got %b want 0", err);
        end
        wait_done(lat);
        tests++;
        if (lat !== 12 || err !== 1'b0) begin
            fails++;
            $display("FAIL abort_next_frame: lat=%0d err=%b want 12 0", lat, err);
        end
    endtask

    task automatic test_start_priority();
        int lat;
        int s_rst;
        s_rst = n_rst;
        @(negedge clk);
        op_wr = 1'b0;
        tb_op = 1'b0;
        num_rows = ROW_W'(2);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        tests++;
        if (busy !== 1'b1 || rsr_rst !== 1'b1 || err !== 1'b0) begin
            fails++;
            $display("FAIL startabort: busy=%b rsr_rst=%b err=%b want 1 1 0",
                     busy, rsr_rst, err);
        end
        repeat (4) @(negedge clk);
        op_wr = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op_wr = 1'b0;
        wait_done(lat);
        tests++;
        if (lat !== 16 || err !== 1'b0 || n_rst - s_rst !== 1) begin
            fails++;
            $display("FAIL busy_start: lat=%0d err=%b rst=%0d want 16 0 1",
                     lat, err, n_rst - s_rst);
        end
    endtask

    task automatic test_async_reset();
        int lat;
        int w;
        kick(1'b0, 8);
        w = 0;
        while (!(row_idx == ROW_W'(5) && cram_wl_en) && w < 200) begin
            @(negedge clk);
            w++;
        end
        tests++;
        if (row_idx !== ROW_W'(5) || cram_wl_en !== 1'b1) begin
            fails++;
            $display("FAIL arst_reach: idx=%0d wl=%b want 5 1", row_idx, cram_wl_en);
        end
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (outs() !== 20'h0) begin
            fails++;
            $display("FAIL arst_outs: got %h want 0", outs());
        end
        @(negedge clk);
        rst = 1'b0;
        kick(1'b0, 2);
        tests++;
        if (rsr_rst !== 1'b1 || busy !== 1'b1 || row_idx !== '0) begin
            fails++;
            $display("FAIL arst_clr: rsr_rst=%b busy=%b idx=%0d want 1 1 0",
                     rsr_rst, busy, row_idx);
        end
        wait_done(lat);
        tests++;
        if (lat !== 21 || err !== 1'b0) begin
            fails++;
            $display("FAIL arst_frame: lat=%0d err=%b want 21 0", lat, err);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_tail_fault();
        test_zero_rows();
        test_abort();
        test_start_priority();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
